// File: rtl/vram_pkg.sv
// Shared defaults and clear-FSM state type for the VRAM arbiter slice.
package vram_pkg;

  localparam int DEF_DEPTH  = 3700;  // 100 columns x 37 rows
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vram_state_e;

endpackage

// File: rtl/vram_arb_if.sv
// Requester and VRAM-side bus of the arbiter; slave = arbiter, master = system/bench.
interface vram_arb_if #(
  parameter int ADDR_W = vram_pkg::DEF_ADDR_W,
  parameter int DATA_W = vram_pkg::DEF_DATA_W
);

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_vld;
  logic [DATA_W-1:0] disp_data;

  // Writer handshake: a word transfers on the rising pclk edge where
  // wr_valid && wr_ready; the writer holds wr_valid/wr_addr/wr_data stable
  // until then, and wr_ready never looks at wr_valid.
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
    input  clr_start, clr_color, ram_rdata,
    output disp_vld, disp_data, wr_ready, clr_busy,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
    output clr_start, clr_color, ram_rdata,
    input  disp_vld, disp_data, wr_ready, clr_busy,
    input  ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/vram_clr_seq.sv
// Full-frame clear sequencer: IDLE/CLEAR FSM, address pointer and latched fill value.
module vram_clr_seq
  import vram_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  input  logic              step,
  output vram_state_e       state,
  output logic [ADDR_W-1:0] ptr,
  output logic [DATA_W-1:0] clr_val,
  output logic              clr_busy,
  output logic              clr_we
);

  vram_state_e state_q, state_d;
  logic        last;

  assign last  = (32'(ptr) >= 32'(DEPTH - 1));
  assign state = state_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_start)   state_d = CLEAR;
      CLEAR:   if (step && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer only advances on cycles the clear actually owns the RAM, so a
  // display access never causes a skipped address. clr_start in CLEAR is ignored.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      clr_val <= '0;
    end else if (state_q == IDLE) begin
      if (clr_start) begin
        ptr     <= '0;
        clr_val <= clr_color;
      end
    end else if (step) begin
      ptr <= last ? '0 : ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    clr_busy = (state_q == CLEAR);
    clr_we   = (state_q == CLEAR) && step && (32'(ptr) < 32'(DEPTH));
  end

endmodule

// File: rtl/vram_arb.sv
// Fixed-priority VRAM arbiter (display > clear > writer) over one single-port RAM.
// Optional VRAM_ARB_STATS_EN adds a saturating writer-stall counter port.
module vram_arb
  import vram_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic        pclk,
  input  logic        rst,
  vram_arb_if.slave   bus,
  output vram_state_e clr_state
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  vram_state_e       state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] clr_val;
  logic              clr_we;
  logic              clr_busy;
  logic              wr_fire;

  vram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_clr_seq (
    .pclk      (pclk),
    .rst       (rst),
    .clr_start (bus.clr_start),
    .clr_color (bus.clr_color),
    .step      (!bus.disp_req),
    .state     (state),
    .ptr       (ptr),
    .clr_val   (clr_val),
    .clr_busy  (clr_busy),
    .clr_we    (clr_we)
  );

  assign clr_state    = state;
  assign bus.clr_busy = clr_busy;
  assign bus.wr_ready = (state == IDLE) && !bus.disp_req;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;

  // Out-of-range writer addresses still complete the handshake but never reach the RAM.
  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (bus.disp_req) begin
      bus.ram_addr = bus.disp_addr;
    end else if (state == CLEAR) begin
      bus.ram_we    = clr_we;
      bus.ram_addr  = ptr;
      bus.ram_wdata = clr_val;
    end else if (wr_fire) begin
      bus.ram_we    = (32'(bus.wr_addr) < 32'(DEPTH));
      bus.ram_addr  = bus.wr_addr;
      bus.ram_wdata = bus.wr_data;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) bus.disp_vld <= 1'b0;
    else     bus.disp_vld <= bus.disp_req;
  end

  assign bus.disp_data = bus.disp_vld ? bus.ram_rdata : '0;

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.wr_valid && !bus.wr_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb with a behavioural synchronous-read VRAM model.
module tb_vram_arb;
  import vram_pkg::*;

  localparam int DEPTH  = DEF_DEPTH;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int DATA_W = DEF_DATA_W;

  logic        pclk;
  logic        rst;
  vram_state_e clr_state;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  vram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) vif ();

  vram_arb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .bus       (vif),
    .clr_state (clr_state)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // VRAM model with per-address write counters
  logic [DATA_W-1:0] mem [DEPTH];
  int                wr_cnt [DEPTH];
  int                wr_total;
  bit                cnt_en;

  always @(posedge pclk) begin
    if (vif.ram_we && (int'(vif.ram_addr) < DEPTH)) begin
      mem[vif.ram_addr] <= vif.ram_wdata;
      if (cnt_en) begin
        wr_cnt[vif.ram_addr] <= wr_cnt[vif.ram_addr] + 1;
        wr_total             <= wr_total + 1;
      end
    end
    vif.ram_rdata <= (int'(vif.ram_addr) < DEPTH) ? mem[vif.ram_addr] : '0;
  end

  // driver helpers
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < DEPTH; i++) wr_cnt[i] = 0;
    wr_total = 0;
  endtask

  task automatic fill_mem(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DEPTH; i++) mem[i] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.disp_req = 1'b0; vif.disp_addr = '0;
    vif.wr_valid = 1'b0; vif.wr_addr = '0; vif.wr_data = '0;
    vif.clr_start = 1'b0; vif.clr_color = '0;
    cnt_en = 1'b0;
    clear_counts();
    fill_mem('0);
    repeat (3) cyc();
    n_cmp++;
    if ({vif.clr_busy, vif.disp_vld, vif.ram_we, clr_state} !== {1'b0, 1'b0, 1'b0, IDLE}) begin
      n_fail++;
      $display("FAIL reset_state: busy/vld/we/state=%b%b%b%0d required 0000",
               vif.clr_busy, vif.disp_vld, vif.ram_we, clr_state);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({vif.wr_ready, vif.ram_addr, vif.ram_wdata} !== {1'b1, 12'h000, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_idle_bus: ready=%b addr=%h wdata=%h required 1 000 000",
               vif.wr_ready, vif.ram_addr, vif.ram_wdata);
    end
  endtask

  task automatic test_display();
    mem[5] = 12'hABC;
    cyc();
    vif.disp_req = 1'b1; vif.disp_addr = 12'd5;
    vif.wr_valid = 1'b1; vif.wr_addr = 12'd5; vif.wr_data = 12'h111;
    #1;
    n_cmp++;
    if ({vif.ram_we, vif.ram_addr, vif.wr_ready} !== {1'b0, 12'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL disp_mux: we=%b addr=%h ready=%b required 0 005 0",
               vif.ram_we, vif.ram_addr, vif.wr_ready);
    end
    cyc();
    vif.disp_req = 1'b0; vif.wr_valid = 1'b0;
    #1;
    n_cmp++;
    if ({vif.disp_vld, vif.disp_data} !== {1'b1, 12'hABC}) begin
      n_fail++;
      $display("FAIL disp_read: vld=%b data=%h required 1 abc", vif.disp_vld, vif.disp_data);
    end
    cyc();
    n_cmp++;
    if ({vif.disp_vld, vif.disp_data, mem[5]} !== {1'b0, 12'h000, 12'hABC}) begin
      n_fail++;
      $display("FAIL disp_idle: vld=%b data=%h mem5=%h required 0 000 abc",
               vif.disp_vld, vif.disp_data, mem[5]);
    end
  endtask

  task automatic test_writer_vs_display();
    int blocked;
    blocked = 0;
    vif.disp_req = 1'b1; vif.disp_addr = 12'd0;
    vif.wr_valid = 1'b1; vif.wr_addr = 12'd7; vif.wr_data = 12'h0F0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (!vif.wr_ready && !vif.ram_we) blocked++;
      cyc();
    end
    n_cmp++;
    if (blocked !== 3) begin
      n_fail++;
      $display("FAIL wr_blocked: blocked_cycles=%0d required 3", blocked);
    end
    vif.disp_req = 1'b0;
    #1;
    n_cmp++;
    if ({vif.wr_ready, vif.ram_we, vif.ram_addr, vif.ram_wdata} !== {1'b1, 1'b1, 12'd7, 12'h0F0}) begin
      n_fail++;
      $display("FAIL wr_accept: ready=%b we=%b addr=%h wdata=%h required 1 1 007 0f0",
               vif.wr_ready, vif.ram_we, vif.ram_addr, vif.ram_wdata);
    end
    cyc();
    vif.wr_valid = 1'b0;
    n_cmp++;
    if (mem[7] !== 12'h0F0) begin
      n_fail++;
      $display("FAIL wr_mem7: mem=%h required 0f0", mem[7]);
    end
  endtask

  task automatic test_drop_and_idle();
    vif.wr_valid = 1'b1; vif.wr_addr = 12'd4000; vif.wr_data = 12'h555;
    #1;
    n_cmp++;
    if ({vif.wr_ready, vif.ram_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_drop: ready=%b we=%b required 1 0", vif.wr_ready, vif.ram_we);
    end
    cyc();
    vif.wr_valid = 1'b0; vif.wr_addr = 12'd3; vif.wr_data = 12'h777;
    #1;
    n_cmp++;
    if ({vif.ram_we, vif.ram_addr, vif.ram_wdata} !== {1'b0, 12'h000, 12'h000}) begin
      n_fail++;
      $display("FAIL no_requester: we=%b addr=%h wdata=%h required 0 000 000",
               vif.ram_we, vif.ram_addr, vif.ram_wdata);
    end
  endtask

  task automatic test_clear();
    int cycles, rdy_bad, bad;
    cyc();
    vif.clr_start = 1'b1; vif.clr_color = 12'h00F;
    vif.wr_valid = 1'b1; vif.wr_addr = 12'd9; vif.wr_data = 12'h123;
    #1;
    n_cmp++;
    if ({vif.ram_we, vif.ram_addr, vif.ram_wdata, vif.clr_busy} !== {1'b1, 12'd9, 12'h123, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_start_write: we=%b addr=%h wdata=%h busy=%b required 1 009 123 0",
               vif.ram_we, vif.ram_addr, vif.ram_wdata, vif.clr_busy);
    end
    cyc();
    vif.clr_start = 1'b0; vif.wr_valid = 1'b0;
    clear_counts();
    cnt_en = 1'b1;
    n_cmp++;
    if ({mem[9], vif.clr_busy, clr_state} !== {12'h123, 1'b1, CLEAR}) begin
      n_fail++;
      $display("FAIL clr_enter: mem9=%h busy=%b state=%0d required 123 1 1",
               mem[9], vif.clr_busy, clr_state);
    end
    cycles = 0; rdy_bad = 0;
    while (vif.clr_busy && cycles < 5000) begin
      cycles++;
      if (vif.wr_ready) rdy_bad++;
      // a restart request mid-clear must be ignored
      vif.clr_start = (cycles == 100);
      vif.clr_color = (cycles == 100) ? 12'hFFF : 12'h00F;
      cyc();
    end
    vif.clr_start = 1'b0;
    cnt_en = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (wr_cnt[i] != 1 || mem[i] != 12'h00F) bad++;
    n_cmp++;
    if ({cycles, wr_total, rdy_bad} !== {32'd3700, 32'd3700, 32'd0}) begin
      n_fail++;
      $display("FAIL clr_count: cycles=%0d writes=%0d ready_hi=%0d required 3700 3700 0",
               cycles, wr_total, rdy_bad);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clr_coverage: bad_addresses=%0d required 0", bad);
    end
    n_cmp++;
    if ({vif.wr_ready, clr_state} !== {1'b1, IDLE}) begin
      n_fail++;
      $display("FAIL clr_exit: ready=%b state=%0d required 1 0", vif.wr_ready, clr_state);
    end
  endtask

  task automatic test_clear_with_display();
    int cycles, bad, we_bad;
    vif.clr_start = 1'b1; vif.clr_color = 12'h0A5;
    cyc();
    vif.clr_start = 1'b0;
    clear_counts();
    cnt_en = 1'b1;
    cycles = 0; we_bad = 0;
    while (vif.clr_busy && cycles < 10000) begin
      vif.disp_req = cycles[0];
      vif.disp_addr = 12'd20;
      #1;
      if (vif.disp_req && vif.ram_we) we_bad++;
      cycles++;
      cyc();
    end
    vif.disp_req = 1'b0;
    cnt_en = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (wr_cnt[i] != 1 || mem[i] != 12'h0A5) bad++;
    n_cmp++;
    if (cycles < 7399 || cycles > 7401 || we_bad != 0) begin
      n_fail++;
      $display("FAIL clr_disp_time: cycles=%0d we_during_disp=%0d required 7399..7401 0",
               cycles, we_bad);
    end
    n_cmp++;
    if ({bad, wr_total} !== {32'd0, 32'd3700}) begin
      n_fail++;
      $display("FAIL clr_disp_coverage: bad=%0d writes=%0d required 0 3700", bad, wr_total);
    end
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    fill_mem(12'h777);
    vif.clr_start = 1'b1; vif.clr_color = 12'h00F;
    cyc();
    vif.clr_start = 1'b0;
    repeat (1000) cyc();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({vif.clr_busy, clr_state, vif.ram_we, vif.disp_vld} !== {1'b0, IDLE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_abort: busy=%b state=%0d we=%b vld=%b required 0 0 0 0",
               vif.clr_busy, clr_state, vif.ram_we, vif.disp_vld);
    end
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 1000 && mem[i] != 12'h00F) bad++;
      if (i >= 1000 && mem[i] != 12'h777) bad++;
    end
    n_cmp++;
    if ({bad, 31'd0, vif.clr_busy} !== {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_partial: bad=%0d busy=%b required 0 0", bad, vif.clr_busy);
    end
  endtask

`ifdef VRAM_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stall_reset: cnt=%0d required 0", stall_cnt);
    end
    vif.disp_req = 1'b1; vif.wr_valid = 1'b1; vif.wr_addr = 12'd1; vif.wr_data = 12'h001;
    repeat (20) cyc();
    n_cmp++;
    if (stall_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL stall_20: cnt=%0d required 20", stall_cnt);
    end
    repeat (65535) cyc();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stall_sat: cnt=%h required ffff", stall_cnt);
    end
    repeat (5) cyc();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stall_hold: cnt=%h required ffff", stall_cnt);
    end
    vif.disp_req = 1'b0; vif.wr_valid = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_display();
    test_writer_vs_display();
    test_drop_and_idle();
    test_clear();
    test_clear_with_display();
    test_reset_mid_clear();
`ifdef VRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
